pipeline_control_unit: RTL and testbench
========================================

Name: pipeline_control_unit

Overview:
- Central sequencer for the 5-stage 16-bit core.
- Turns hazard-unit requests (load-use nop, bne flush), data-memory wait handshakes and halt requests into per-stage enable/clear strobes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Also keeps saturating stall/flush performance counters.
- Sits beside the hazard detection unit; its outputs drive the pipeline registers directly.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7).
- MEM_TIMEOUT, 15, max MEM_WAIT cycles before mem_error (1..255).
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- hazard_nop  in  2  2'b01 = load-use bubble request; other values = none
- hazard_flush  in  2  2'b01 = taken-branch flush request; other values = none
- mem_req  in  1  EX/MEM stage issuing data-memory access this cycle
- mem_ready  in  1  data memory completes access this cycle
- halt_req  in  1  halt opcode decoded
- resume  in  1  leave HALT
- cnt_clr  in  1  synchronous clear of both counters
- pc_en  out  1  PC register load enable
- if_id_en  out  1  IF/ID enable
- if_id_clr  out  1  IF/ID synchronous clear
- id_ex_en  out  1  ID/EX enable
- id_ex_clr  out  1  ID/EX synchronous clear (bubble)
- ex_mem_en  out  1  EX/MEM enable
- mem_wb_en  out  1  MEM/WB enable
- mem_wb_clr  out  1  MEM/WB clear
- halted  out  1  state == HALT
- mem_error  out  1  sticky timeout flag
- stall_count  out  CNT_W  cycles with pc_en=0 outside HALT
- flush_count  out  CNT_W  accepted flushes

Behaviour:
- States: RUN, LOAD_STALL, MEM_WAIT, HALT. Reset → RUN.
- Reset values: counters 0, mem_error 0, internal stall counter 0.
- Strobes are Mealy: combinational from state plus current inputs, zero-cycle latency. Counters and state are registered.
- Default strobes (RUN, no event): all *_en=1, all *_clr=0.
- Priority within a cycle: mem wait > flush > load stall > halt.
- Mem wait: mem_req=1 and mem_ready=0.
  - All *_en=0; mem_wb_clr=1.
  - Go to MEM_WAIT with timer=1.
  - mem_req=1 with mem_ready=1 in the same cycle: no stall.
- MEM_WAIT:
  - Same strobes every cycle.
  - Timer increments each cycle.
  - mem_ready=1: strobes return to default this cycle; next state RUN.
  - Timer reaches MEM_TIMEOUT without mem_ready: mem_error<=1, next state HALT.
- Flush (hazard_flush==2'b01 in RUN): if_id_clr=1, everything else default. Any simultaneous hazard_nop is ignored. flush_count +1.
- Load stall (hazard_nop==2'b01 in RUN, no flush):
  - pc_en=0, if_id_en=0, id_ex_clr=1.
  - If LOAD_STALL_CYCLES>1: enter LOAD_STALL, which repeats the same strobes for LOAD_STALL_CYCLES-1 further cycles, then returns to RUN.
- LOAD_STALL and mem wait: a mem wait arising in LOAD_STALL preempts it. The remaining bubble count is discarded; MEM_WAIT exits to RUN.
- halt_req in RUN with no higher event:
  - Current cycle default; next state HALT.
  - HALT: pc_en=0, if_id_en=0, id_ex_clr=1; ex_mem/mem_wb enabled (drain).
  - resume=1 in HALT: default strobes this cycle, next state RUN, mem_error cleared.
  - hazard inputs are ignored in HALT.
- stall_count:
  - +1 every cycle pc_en=0 and state!=HALT.
  - Saturates at all-ones; flush_count saturates likewise.
  - cnt_clr has priority over increment.
- Async reset mid-MEM_WAIT or mid-LOAD_STALL returns to RUN with reset values immediately.

Decomposition:
- Shared package core_ctrl_pkg:
  - state enum ctrl_state_t.
  - HAZ_REQ = 2'b01 encoding of the hazard unit's nop/flush requests.
- Sub-module sat_counter (CNT_W, inc, clr) instantiated twice for the performance counters.

Test Plan:
- Reset, then idle in RUN → all en=1, clr=0, counters 0.
- hazard_nop=01 for one cycle, LOAD_STALL_CYCLES=2 → pc_en=0 and id_ex_clr=1 for exactly 2 cycles, then default. stall_count=2.
- hazard_nop=01 and hazard_flush=01 together → if_id_clr=1, pc_en=1, flush_count=1, stall_count unchanged.
- mem_req=1, mem_ready low 3 cycles then high → all en=0 for 3 cycles; mem_wb_clr=1 during wait; RUN on cycle 4; stall_count=3.
- mem_req=1, mem_ready never, MEM_TIMEOUT=15 → mem_error=1, halted=1 after 15 cycles. Then resume pulse → RUN, mem_error=0.
- stall_count preloaded near 0xFFFF via long stall → holds 0xFFFF. cnt_clr with a simultaneous stall → 0.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared types for the core pipeline sequencer: FSM state encoding and the
// hazard-unit request code.
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2,
        ST_HALT       = 2'd3
    } ctrl_state_t;

    localparam logic [1:0] HAZ_REQ = 2'b01;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// One-cycle update latency; no backpressure, holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline sequencer: per-stage enable/clear strobes, Mealy (zero-cycle) from state and inputs.
// Stalls on load-use, memory wait and halt; memory wait has top priority.
module pipeline_control_unit
    import core_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 15,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       hazard_nop,
    input  logic [1:0]       hazard_flush,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             cnt_clr,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_clr,
    output logic             id_ex_en,
    output logic             id_ex_clr,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             mem_wb_clr,
    output logic             halted,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [7:0] TIMEOUT  = 8'(MEM_TIMEOUT);
    localparam logic [2:0] LS_EXTRA = 3'(LOAD_STALL_CYCLES - 1);

    ctrl_state_t r_state, w_state_nxt;
    logic [7:0]  r_timer, w_timer_nxt;
    logic [2:0]  r_ls_left, w_ls_left_nxt;
    logic        r_mem_error, w_mem_error_nxt;
    logic        w_mem_wait, w_flush_req, w_nop_req;
    logic        w_stall_inc, w_flush_inc;

    assign w_mem_wait  = mem_req && !mem_ready;
    assign w_flush_req = (hazard_flush == HAZ_REQ);
    assign w_nop_req   = (hazard_nop == HAZ_REQ);

    always_comb begin
        pc_en           = 1'b1;
        if_id_en        = 1'b1;
        if_id_clr       = 1'b0;
        id_ex_en        = 1'b1;
        id_ex_clr       = 1'b0;
        ex_mem_en       = 1'b1;
        mem_wb_en       = 1'b1;
        mem_wb_clr      = 1'b0;
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_ls_left_nxt   = r_ls_left;
        w_mem_error_nxt = r_mem_error;
        w_flush_inc     = 1'b0;

        case (r_state)
            ST_RUN, ST_LOAD_STALL: begin
                if (w_mem_wait) begin
                    // Freeze everything and squash whatever would leave MEM; a pending bubble count is dropped.
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    id_ex_en      = 1'b0;
                    ex_mem_en     = 1'b0;
                    mem_wb_en     = 1'b0;
                    mem_wb_clr    = 1'b1;
                    w_timer_nxt   = 8'd1;
                    w_ls_left_nxt = 3'd0;
                    if (TIMEOUT <= 8'd1) begin
                        w_mem_error_nxt = 1'b1;
                        w_state_nxt     = ST_HALT;
                    end else begin
                        w_state_nxt = ST_MEM_WAIT;
                    end
                end else if (r_state == ST_LOAD_STALL) begin
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    id_ex_clr     = 1'b1;
                    w_ls_left_nxt = r_ls_left - 3'd1;
                    if (r_ls_left <= 3'd1) begin
                        w_state_nxt = ST_RUN;
                    end
                end else if (w_flush_req) begin
                    if_id_clr   = 1'b1;
                    w_flush_inc = 1'b1;
                end else if (w_nop_req) begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_clr = 1'b1;
                    if (LS_EXTRA != 3'd0) begin
                        w_ls_left_nxt = LS_EXTRA;
                        w_state_nxt   = ST_LOAD_STALL;
                    end
                end else if (halt_req) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_en    = 1'b0;
                    ex_mem_en   = 1'b0;
                    mem_wb_en   = 1'b0;
                    mem_wb_clr  = 1'b1;
                    w_timer_nxt = r_timer + 8'd1;
                    if (w_timer_nxt >= TIMEOUT) begin
                        w_mem_error_nxt = 1'b1;
                        w_state_nxt     = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                if (resume) begin
                    w_state_nxt     = ST_RUN;
                    w_mem_error_nxt = 1'b0;
                end else begin
                    // Front end frozen with bubbles injected; back end keeps draining.
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_clr = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_timer     <= 8'd0;
            r_ls_left   <= 3'd0;
            r_mem_error <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_ls_left   <= w_ls_left_nxt;
            r_mem_error <= w_mem_error_nxt;
        end
    end

    assign w_stall_inc = !pc_en && (r_state != ST_HALT);
    assign halted      = (r_state == ST_HALT);
    assign mem_error   = r_mem_error;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_stall_inc),
        .i_clr   (cnt_clr),
        .o_count (stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_flush_inc),
        .i_clr   (cnt_clr),
        .o_count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench for pipeline_control_unit: a per-cycle vector table plus
// hand sequences for timeout, counter saturation and async reset.
module tb_pipeline_control_unit;

    localparam int CNT_W = 8;

    // Strobe order: pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr, ex_mem_en, mem_wb_en, mem_wb_clr
    localparam logic [7:0] S_DEF = 8'b1101_0110;
    localparam logic [7:0] S_FL  = 8'b1111_0110;
    localparam logic [7:0] S_ST  = 8'b0001_1110;
    localparam logic [7:0] S_MW  = 8'b0000_0001;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       hazard_nop, hazard_flush;
    logic             mem_req, mem_ready, halt_req, resume, cnt_clr;
    logic             pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr;
    logic             ex_mem_en, mem_wb_en, mem_wb_clr, halted, mem_error;
    logic [CNT_W-1:0] stall_count, flush_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_control_unit #(
        .LOAD_STALL_CYCLES (2),
        .MEM_TIMEOUT       (15),
        .CNT_W             (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hazard_nop   (hazard_nop),
        .hazard_flush (hazard_flush),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .halt_req     (halt_req),
        .resume       (resume),
        .cnt_clr      (cnt_clr),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_clr    (if_id_clr),
        .id_ex_en     (id_ex_en),
        .id_ex_clr    (id_ex_clr),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_en    (mem_wb_en),
        .mem_wb_clr   (mem_wb_clr),
        .halted       (halted),
        .mem_error    (mem_error),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    typedef struct {
        logic [1:0] nop;
        logic [1:0] flush;
        logic       mreq;
        logic       mrdy;
        logic       hlt;
        logic       res;
        logic       clr;
        logic [25:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int nop, input int flush, input int mreq, input int mrdy,
                                input int hlt, input int res, input int clr,
                                input logic [7:0] strb, input int hl, input int err,
                                input int sc, input int fc);
        vec_t v;
        v.nop   = 2'(nop);
        v.flush = 2'(flush);
        v.mreq  = 1'(mreq);
        v.mrdy  = 1'(mrdy);
        v.hlt   = 1'(hlt);
        v.res   = 1'(res);
        v.clr   = 1'(clr);
        v.exp   = {strb, 1'(hl), 1'(err), 8'(sc), 8'(fc)};
        return v;
    endfunction

    function automatic logic [25:0] mkexp(input logic [7:0] strb, input int hl, input int err,
                                          input int sc, input int fc);
        return {strb, 1'(hl), 1'(err), 8'(sc), 8'(fc)};
    endfunction

    function automatic logic [25:0] obs();
        return {pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr, ex_mem_en, mem_wb_en, mem_wb_clr,
                halted, mem_error, stall_count, flush_count};
    endfunction

    task automatic drive(input int nop, input int flush, input int mreq, input int mrdy,
                         input int hlt, input int res, input int clr);
        hazard_nop   = 2'(nop);
        hazard_flush = 2'(flush);
        mem_req      = 1'(mreq);
        mem_ready    = 1'(mrdy);
        halt_req     = 1'(hlt);
        resume       = 1'(res);
        cnt_clr      = 1'(clr);
    endtask

    task automatic check(input string name, input logic [25:0] exp);
        logic [25:0] act;
        act = obs();
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got strb=%b hlt=%b err=%b stall=%0d flush=%0d, want strb=%b hlt=%b err=%b stall=%0d flush=%0d",
                     name, act[25:18], act[17], act[16], act[15:8], act[7:0],
                     exp[25:18], exp[17], exp[16], exp[15:8], exp[7:0]);
        end
    endtask

    task automatic cycle(input string name, input int nop, input int flush, input int mreq,
                         input int mrdy, input int hlt, input int res, input int clr,
                         input logic [25:0] exp);
        @(negedge clk);
        drive(nop, flush, mreq, mrdy, hlt, res, clr);
        #1;
        check(name, exp);
    endtask

    initial begin
        // nop flush mreq mrdy halt res clr | strobes halted err stall flush (values seen this cycle)
        vecs.push_back(mk(0,0,0,0,0,0,0, S_DEF,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, S_DEF,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0, S_ST ,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, S_ST ,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, S_DEF,0,0,2,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, S_FL ,0,0,2,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, S_DEF,0,0,2,1));
        vecs.push_back(mk(2,0,0,0,0,0,0, S_DEF,0,0,2,1));
        vecs.push_back(mk(0,3,0,0,0,0,0, S_DEF,0,0,2,1));
        vecs.push_back(mk(0,0,1,1,0,0,0, S_DEF,0,0,2,1));
        vecs.push_back(mk(0,0,1,0,0,0,0, S_MW ,0,0,2,1));
        vecs.push_back(mk(0,0,1,0,0,0,0, S_MW ,0,0,3,1));
        vecs.push_back(mk(0,1,1,0,0,0,0, S_MW ,0,0,4,1));
        vecs.push_back(mk(0,0,1,1,0,0,0, S_DEF,0,0,5,1));
        vecs.push_back(mk(0,0,0,0,0,0,0, S_DEF,0,0,5,1));
        vecs.push_back(mk(1,0,0,0,0,0,0, S_ST ,0,0,5,1));
        vecs.push_back(mk(0,0,1,0,0,0,0, S_MW ,0,0,6,1));
        vecs.push_back(mk(0,0,1,1,0,0,0, S_DEF,0,0,7,1));
        vecs.push_back(mk(0,0,0,0,0,0,0, S_DEF,0,0,7,1));
        vecs.push_back(mk(1,0,0,0,1,0,0, S_ST ,0,0,7,1));
        vecs.push_back(mk(0,0,0,0,1,0,0, S_ST ,0,0,8,1));
        vecs.push_back(mk(0,0,0,0,1,0,0, S_DEF,0,0,9,1));
        vecs.push_back(mk(1,1,0,0,0,0,0, S_ST ,1,0,9,1));
        vecs.push_back(mk(0,0,0,0,0,0,0, S_ST ,1,0,9,1));
        vecs.push_back(mk(0,0,0,0,0,1,0, S_DEF,1,0,9,1));
        vecs.push_back(mk(1,0,0,0,0,0,1, S_ST ,0,0,9,1));
        vecs.push_back(mk(0,0,0,0,0,0,0, S_ST ,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,1, S_DEF,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, S_DEF,0,0,0,0));

        rst_n = 1'b0;
        drive(0,0,0,0,0,0,0);
        repeat (2) @(negedge clk);
        #1;
        check("reset", mkexp(S_DEF,0,0,0,0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].nop, vecs[i].flush, vecs[i].mreq, vecs[i].mrdy,
                  vecs[i].hlt, vecs[i].res, vecs[i].clr);
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Memory never answers: 15 wait cycles, then HALT with mem_error.
        for (int i = 0; i < 15; i++) begin
            cycle($sformatf("tmo_wait%0d", i), 0,0,1,0,0,0,0, mkexp(S_MW,0,0,i,0));
        end
        cycle("tmo_halted", 0,0,1,0,0,0,0, mkexp(S_ST,1,1,15,0));
        cycle("tmo_resume", 0,0,0,0,0,1,0, mkexp(S_DEF,1,1,15,0));
        cycle("tmo_run",    0,0,0,0,0,0,0, mkexp(S_DEF,0,0,15,0));

        // Continuous load-use stalls drive stall_count into saturation (even count ends in RUN).
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            drive(1,0,0,0,0,0,0);
        end
        cycle("sat_stall_clr", 1,0,0,0,0,0,1, mkexp(S_ST,0,0,255,0));
        cycle("sat_after_clr", 0,0,0,0,0,0,0, mkexp(S_ST,0,0,0,0));

        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            drive(0,1,0,0,0,0,0);
        end
        cycle("sat_flush",      0,0,0,0,0,0,0, mkexp(S_DEF,0,0,1,255));
        cycle("sat_flush_more", 0,1,0,0,0,0,0, mkexp(S_FL ,0,0,1,255));
        cycle("sat_flush_hold", 0,0,0,0,0,0,0, mkexp(S_DEF,0,0,1,255));

        // Async reset in the middle of MEM_WAIT.
        cycle("rst_mw_enter", 0,0,1,0,0,0,0, mkexp(S_MW,0,0,1,255));
        cycle("rst_mw_in",    0,0,1,0,0,0,0, mkexp(S_MW,0,0,2,255));
        drive(0,0,0,0,0,0,0);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mw_async", mkexp(S_DEF,0,0,0,0));
        @(negedge clk);
        rst_n = 1'b1;
        cycle("rst_mw_after", 0,0,0,0,0,0,0, mkexp(S_DEF,0,0,0,0));

        // Async reset in the middle of LOAD_STALL.
        cycle("rst_ls_enter", 1,0,0,0,0,0,0, mkexp(S_ST,0,0,0,0));
        #1;
        rst_n = 1'b0;
        drive(0,0,0,0,0,0,0);
        #1;
        check("rst_ls_async", mkexp(S_DEF,0,0,0,0));
        @(negedge clk);
        rst_n = 1'b1;
        cycle("rst_ls_after", 0,0,0,0,0,0,0, mkexp(S_DEF,0,0,0,0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
